alu_operand_issuer: RTL and testbench
=====================================

// Module: alu_operand_issuer
// PURPOSE
//  Feeds operand pairs to unsigned_adder and returns its result to the host.
//  - Accepts a byte stream on a valid/ready handshake: 1st byte = op1, 2nd byte = op2.
//  - Issues the pair with a one-cycle valid pulse, waits the adder latency, captures the sum.
//  - Returns the sum on a valid/ready result port.
// PARAMETERS
//  WIDTH        8  operand/sum width; must match the adder
//  ADD_LATENCY  2  clock edges from the valid_o cycle until sum_i is stable; legal range 1..15
//  CNT_W        16 width of the completed-operation counter
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  in_data_i    in   WIDTH  operand byte from host
//  in_valid_i   in   1      in_data_i valid
//  in_ready_o   out  1      issuer accepts in_data_i
//  op1_o        out  WIDTH  to adder op1_i
//  op2_o        out  WIDTH  to adder op2_i
//  valid_o      out  1      to adder valid_i; one-cycle pulse per pair
//  sum_i        in   WIDTH  from adder sum_o
//  res_data_o   out  WIDTH  captured sum
//  res_valid_o  out  1      res_data_o valid
//  res_ready_i  in   1      host takes result
//  busy_o       out  1      high whenever state != LOAD1
//  done_cnt_o   out  CNT_W  completed result transfers; wraps at 2^CNT_W
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset (async, rst_n=0): state=LOAD1, counter=0, all outputs 0.
//    - in_ready_o rises on the first clk edge after rst_n deasserts.
//  - Transfer = in_valid_i & in_ready_o at a rising edge. Likewise for res_valid_o & res_ready_i.
//  - FSM:
//    - LOAD1: ready=1. On transfer, op1_o<=in_data_i and go to LOAD2.
//    - LOAD2: ready=1. On transfer, op2_o<=in_data_i, ready<=0, valid_o<=1, go to ISSUE.
//    - ISSUE: exactly 1 cycle with valid_o=1. Then valid_o<=0, cnt<=ADD_LATENCY-1, go to WAIT.
//    - WAIT: lasts ADD_LATENCY cycles.
//      - Counts down to 0.
//      - On the edge leaving WAIT: res_data_o<=sum_i, res_valid_o<=1, go to RESULT.
//    - RESULT: hold res_data_o/res_valid_o until transfer.
//      - On transfer: res_valid_o<=0, done_cnt_o+1, ready<=1, go to LOAD1.
//  - op1_o/op2_o hold their values outside loads. The adder ignores them while valid_o=0.
//  - in_valid_i is ignored outside LOAD1/LOAD2. in_data_i is don't-care then.
//  - res_ready_i is ignored outside RESULT.
//  - If res_ready_i is high on RESULT entry, the result transfers in the first RESULT cycle.
//  - Minimum period per pair: 6 cycles (LOAD1, LOAD2, ISSUE, 2xWAIT, RESULT) at ADD_LATENCY=2.
//  - Arithmetic: no local math. The sum is the adder's WIDTH-bit modulo result (255+1 -> 0).
//  - done_cnt_o wraps from 2^CNT_W-1 to 0 with no flag.
//  - Reset mid-operation:
//    - valid_o and res_valid_o drop immediately (async).
//    - A half-loaded pair is discarded. An uncollected result is lost.
//  - in_valid_i held high continuously: bytes pair strictly in arrival order. No byte is dropped or duplicated.
// STRUCTURE
//  - Shared header alu_defs.vh: state encodings LOAD1..RESULT as 3-bit localparams, ALU_WIDTH=8.
//  - Single flat module. The latency countdown is inline. No sub-module is needed.
// TESTING (bench instantiates alu_operand_issuer + unsigned_adder, ADD_LATENCY=2)
//  1. Reset then bytes 0x12, 0x34 with res_ready_i=1:
//     -> valid_o high exactly 1 cycle with op1_o=0x12, op2_o=0x34
//     -> res_data_o=0x46 3 cycles later; done_cnt_o=1.
//  2. Bytes 0xFF, 0x01 -> res_data_o=0x00 (wrap).
//     Then 0x80, 0x80 -> 0x00. Then 0x7F, 0x80 -> 0xFF.
//  3. res_ready_i=0 for 10 cycles in RESULT:
//     -> res_valid_o and res_data_o stable, in_ready_o=0
//     -> bytes offered meanwhile are not consumed; the next pair is correct after release.
//  4. in_valid_i held high with 8 bytes 1..8:
//     -> results 3, 7, 11, 15 in order; exactly 4 valid_o pulses; done_cnt_o=4.
//  5. rst_n pulsed low in WAIT, and separately after op1 is loaded:
//     -> outputs 0 immediately; the next pair 0x05, 0x06 yields 0x0B.
//  6. CNT_W=4: 17 operations -> done_cnt_o reads 1.

Source files
------------

// File: rtl/alu_operand_issuer_pkg.sv
// Shared definitions for the ALU operand issuer: operand width, FSM state
// encoding and the latency-countdown preset helper.
package alu_operand_issuer_pkg;

  // Default operand/sum width, matching the external unsigned adder.
  localparam int ALU_WIDTH = 8;

  // Width of the adder-latency countdown; covers latencies 1..15.
  localparam int LAT_CNT_W = 4;
  localparam int ADD_LATENCY_MIN = 1;
  localparam int ADD_LATENCY_MAX = 15;

  // Issuer sequencing states.
  typedef enum logic [2:0] {
    ST_LOAD1  = 3'd0,
    ST_LOAD2  = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESULT = 3'd4
  } state_e;

  // Countdown preset for the WAIT state. The state lasts 'latency' cycles,
  // so the counter starts at latency-1 and leaves WAIT when it reads zero.
  // Out-of-range latencies are clamped so the counter can never overflow.
  function automatic logic [LAT_CNT_W-1:0] wait_preset(input int latency);
    int clamped;
    if (latency < ADD_LATENCY_MIN) begin
      clamped = ADD_LATENCY_MIN;
    end else if (latency > ADD_LATENCY_MAX) begin
      clamped = ADD_LATENCY_MAX;
    end else begin
      clamped = latency;
    end
    return LAT_CNT_W'(clamped - 1);
  endfunction

endpackage

// File: rtl/alu_operand_issuer_chk.sv
// Protocol checker for the operand issuer. Observes the registered outputs
// and state and flags illegal combinations; it drives nothing.
module alu_operand_issuer_chk
  import alu_operand_issuer_pkg::*;
(
  input logic   clk,
  input logic   rst_n,
  input state_e state,
  input logic   in_ready,
  input logic   valid,
  input logic   res_valid,
  input logic   busy
);

  // The adder strobe is a single-cycle pulse per operand pair.
  a_valid_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    valid |=> !valid);

  // The adder strobe only appears while the pair is being issued.
  a_valid_in_issue: assert property (@(posedge clk) disable iff (!rst_n)
    valid |-> (state == ST_ISSUE));

  // Busy mirrors "not idle in LOAD1" at every clock.
  a_busy_state: assert property (@(posedge clk) disable iff (!rst_n)
    busy == (state != ST_LOAD1));

  // The issuer never accepts input while it is presenting a result.
  a_ready_vs_result: assert property (@(posedge clk) disable iff (!rst_n)
    !(in_ready && res_valid));

  // A presented result is only ever visible in the RESULT state.
  a_result_state: assert property (@(posedge clk) disable iff (!rst_n)
    res_valid |-> (state == ST_RESULT));

endmodule

// File: rtl/alu_operand_issuer.sv
// ALU operand issuer: collects two operand bytes from a valid/ready stream,
// strobes them into an external fixed-latency adder, captures the sum after
// the adder latency and hands it back on a valid/ready result port.
// All outputs are registered.
module alu_operand_issuer
  import alu_operand_issuer_pkg::*;
#(
  parameter int WIDTH       = ALU_WIDTH,
  parameter int ADD_LATENCY = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] op1_o,
  output logic [WIDTH-1:0] op2_o,
  output logic             valid_o,
  input  logic [WIDTH-1:0] sum_i,
  output logic [WIDTH-1:0] res_data_o,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] done_cnt_o
);

  localparam logic [LAT_CNT_W-1:0] LAT_PRESET = wait_preset(ADD_LATENCY);
  localparam logic [LAT_CNT_W-1:0] LAT_ZERO   = {LAT_CNT_W{1'b0}};
  localparam logic [LAT_CNT_W-1:0] LAT_ONE    = {{(LAT_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]     DONE_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e               state_r;
  logic [LAT_CNT_W-1:0] lat_cnt_r;
  logic                 in_xfer_s;
  logic                 res_xfer_s;

  // Handshake completions, qualified by the registered ready/valid outputs.
  always_comb begin
    in_xfer_s  = in_valid_i & in_ready_o;
    res_xfer_s = res_valid_o & res_ready_i;
  end

  // Operand sequencing FSM with registered outputs and the inline latency countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_LOAD1;
      lat_cnt_r   <= LAT_ZERO;
      in_ready_o  <= 1'b0;
      op1_o       <= {WIDTH{1'b0}};
      op2_o       <= {WIDTH{1'b0}};
      valid_o     <= 1'b0;
      res_data_o  <= {WIDTH{1'b0}};
      res_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      done_cnt_o  <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_LOAD1: begin
          // Ready comes up on the first edge after reset and stays up here.
          in_ready_o <= 1'b1;
          if (in_xfer_s) begin
            op1_o   <= in_data_i;
            busy_o  <= 1'b1;
            state_r <= ST_LOAD2;
          end
        end

        ST_LOAD2: begin
          in_ready_o <= 1'b1;
          if (in_xfer_s) begin
            op2_o      <= in_data_i;
            in_ready_o <= 1'b0;
            valid_o    <= 1'b1;
            state_r    <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          // The adder has sampled the pair; start timing its latency.
          valid_o   <= 1'b0;
          lat_cnt_r <= LAT_PRESET;
          state_r   <= ST_WAIT;
        end

        ST_WAIT: begin
          if (lat_cnt_r == LAT_ZERO) begin
            res_data_o  <= sum_i;
            res_valid_o <= 1'b1;
            state_r     <= ST_RESULT;
          end else begin
            lat_cnt_r <= lat_cnt_r - LAT_ONE;
          end
        end

        ST_RESULT: begin
          if (res_xfer_s) begin
            res_valid_o <= 1'b0;
            done_cnt_o  <= done_cnt_o + DONE_ONE;
            in_ready_o  <= 1'b1;
            busy_o      <= 1'b0;
            state_r     <= ST_LOAD1;
          end
        end

        default: begin
          // Unreachable encoding: fall back to a clean idle state.
          state_r     <= ST_LOAD1;
          lat_cnt_r   <= LAT_ZERO;
          in_ready_o  <= 1'b0;
          valid_o     <= 1'b0;
          res_valid_o <= 1'b0;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end

  alu_operand_issuer_chk u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .state     (state_r),
    .in_ready  (in_ready_o),
    .valid     (valid_o),
    .res_valid (res_valid_o),
    .busy      (busy_o)
  );

endmodule

// File: tb/tb_alu_operand_issuer.sv
// Directed bench for alu_operand_issuer with a behavioural 2-cycle adder.
// A second instance with a 4-bit done counter shares the stimulus to
// exercise counter wrap.
module tb_alu_operand_issuer;

  localparam int W   = 8;
  localparam int LAT = 2;
  localparam int TMO = 60;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] in_data = 8'h00;
  logic         in_valid = 1'b0;
  logic         res_ready = 1'b0;

  logic         in_ready, valid, res_valid, busy;
  logic [W-1:0] op1, op2, sum, res_data;
  logic [15:0]  done_cnt;

  logic         in_ready4, valid4, res_valid4, busy4;
  logic [W-1:0] op1_4, op2_4, sum4, res_data4;
  logic [3:0]   done_cnt4;

  logic [W-1:0] pipe   [LAT];
  logic [W-1:0] pipe4  [LAT];

  int n_checks = 0;
  int n_pass   = 0;

  int cyc = 0;
  int pulses = 0;
  int long_pulses = 0;
  int t_valid = 0;
  int t_res = 0;
  logic [W-1:0] last_op1 = 8'h00;
  logic [W-1:0] last_op2 = 8'h00;
  logic prev_valid = 1'b0;
  logic prev_res = 1'b0;

  always #5 clk = ~clk;

  alu_operand_issuer #(.WIDTH(W), .ADD_LATENCY(LAT), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_data_i(in_data), .in_valid_i(in_valid),
    .in_ready_o(in_ready), .op1_o(op1), .op2_o(op2), .valid_o(valid),
    .sum_i(sum), .res_data_o(res_data), .res_valid_o(res_valid),
    .res_ready_i(res_ready), .busy_o(busy), .done_cnt_o(done_cnt)
  );

  alu_operand_issuer #(.WIDTH(W), .ADD_LATENCY(LAT), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_data_i(in_data), .in_valid_i(in_valid),
    .in_ready_o(in_ready4), .op1_o(op1_4), .op2_o(op2_4), .valid_o(valid4),
    .sum_i(sum4), .res_data_o(res_data4), .res_valid_o(res_valid4),
    .res_ready_i(res_ready), .busy_o(busy4), .done_cnt_o(done_cnt4)
  );

  // Behavioural unsigned adders: sample on the valid edge, stable LAT-1 edges later.
  always @(posedge clk) begin
    if (valid) pipe[0] <= op1 + op2;
    if (valid4) pipe4[0] <= op1_4 + op2_4;
    for (int k = 1; k < LAT; k++) begin
      pipe[k]  <= pipe[k-1];
      pipe4[k] <= pipe4[k-1];
    end
  end
  assign sum  = pipe[LAT-1];
  assign sum4 = pipe4[LAT-1];

  // Monitor of the adder strobe and result timing, sampled mid-cycle.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    prev_valid <= valid;
    prev_res <= res_valid;
    if (valid) begin
      pulses   <= pulses + 1;
      last_op1 <= op1;
      last_op2 <= op2;
      t_valid  <= cyc;
    end
    if (valid && prev_valid) long_pulses <= long_pulses + 1;
    if (res_valid && !prev_res) t_res <= cyc;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic do_reset(input bit chk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    if (chk) begin
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_valid", {31'd0, valid}, 32'd0);
      check("rst_res_valid", {31'd0, res_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done_cnt", {16'd0, done_cnt}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [W-1:0] b);
    int n;
    in_valid = 1'b1;
    in_data = b;
    n = 0;
    while (!in_ready && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TMO) check("send_timeout", 32'd1, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic get_result(output logic [W-1:0] r);
    int n;
    res_ready = 1'b1;
    n = 0;
    while (!res_valid && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TMO) check("result_timeout", 32'd1, 32'd0);
    r = res_data;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic do_pair(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp);
    logic [W-1:0] r;
    send_byte(a);
    send_byte(b);
    get_result(r);
    check(tag, {24'd0, r}, {24'd0, exp});
  endtask

  initial begin
    logic [W-1:0] r;
    logic [W-1:0] snap;
    logic [W-1:0] got [4];
    int base, errs, n;

    // 1. Reset state, then a basic pair with the host always ready.
    do_reset(1'b1);
    check("ready_after_reset", {31'd0, in_ready}, 32'd1);
    base = pulses;
    res_ready = 1'b1;
    send_byte(8'h12);
    check("busy_after_op1", {31'd0, busy}, 32'd1);
    send_byte(8'h34);
    get_result(r);
    res_ready = 1'b0;
    @(negedge clk);
    check("sum_12_34", {24'd0, r}, 32'h46);
    check("issued_op1", {24'd0, last_op1}, 32'h12);
    check("issued_op2", {24'd0, last_op2}, 32'h34);
    check("valid_pulses_1", pulses - base, 32'd1);
    check("valid_long", long_pulses, 32'd0);
    check("result_latency", t_res - t_valid, 32'd3);
    check("done_cnt_1", {16'd0, done_cnt}, 32'd1);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // 2. Modulo-wrap boundary sums.
    do_pair("sum_ff_01", 8'hFF, 8'h01, 8'h00);
    do_pair("sum_80_80", 8'h80, 8'h80, 8'h00);
    do_pair("sum_7f_80", 8'h7F, 8'h80, 8'hFF);
    check("done_cnt_4", {16'd0, done_cnt}, 32'd4);

    // 3. Host stalls the result for 10 cycles while bytes are offered.
    send_byte(8'h21);
    send_byte(8'h43);
    n = 0;
    while (!res_valid && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TMO) check("stall_timeout", 32'd1, 32'd0);
    snap = res_data;
    check("stall_sum", {24'd0, snap}, 32'h64);
    in_valid = 1'b1;
    in_data = 8'hAA;
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!res_valid || res_data !== snap || in_ready) errs++;
    end
    in_valid = 1'b0;
    check("stall_stable", errs, 32'd0);
    check("stall_done_cnt", {16'd0, done_cnt}, 32'd4);
    get_result(r);
    check("stall_release", {24'd0, r}, 32'h64);
    do_pair("after_stall", 8'h10, 8'h20, 8'h30);
    check("after_stall_op1", {24'd0, last_op1}, 32'h10);

    // 4. Continuous stream of bytes 1..8 with the host always ready.
    do_reset(1'b0);
    base = pulses;
    fork
      begin
        in_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
          in_data = W'(i);
          n = 0;
          while (!in_ready && n < TMO) begin
            @(negedge clk);
            n++;
          end
          if (n >= TMO) check("stream_timeout", 32'd1, 32'd0);
          @(negedge clk);
        end
        in_valid = 1'b0;
      end
      begin
        res_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
          int m;
          m = 0;
          while (!res_valid && m < 2 * TMO) begin
            @(negedge clk);
            m++;
          end
          if (m >= 2 * TMO) check("collect_timeout", 32'd1, 32'd0);
          got[k] = res_data;
          @(negedge clk);
        end
        res_ready = 1'b0;
      end
    join
    check("stream_r0", {24'd0, got[0]}, 32'd3);
    check("stream_r1", {24'd0, got[1]}, 32'd7);
    check("stream_r2", {24'd0, got[2]}, 32'd11);
    check("stream_r3", {24'd0, got[3]}, 32'd15);
    check("stream_pulses", pulses - base, 32'd4);
    check("stream_done_cnt", {16'd0, done_cnt}, 32'd4);

    // 5. Resets in ISSUE, in WAIT, after op1 and while a result is pending.
    send_byte(8'h33);
    send_byte(8'h44);
    check("issue_valid_high", {31'd0, valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("issue_rst_valid", {31'd0, valid}, 32'd0);
    check("issue_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_byte(8'h33);
    send_byte(8'h44);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("wait_rst_busy", {31'd0, busy}, 32'd0);
    check("wait_rst_ready", {31'd0, in_ready}, 32'd0);
    check("wait_rst_done", {16'd0, done_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_byte(8'h99);
    do_reset(1'b0);
    do_pair("post_reset_pair", 8'h05, 8'h06, 8'h0B);
    send_byte(8'h01);
    send_byte(8'h02);
    n = 0;
    while (!res_valid && n < TMO) begin
      @(negedge clk);
      n++;
    end
    rst_n = 1'b0;
    #1;
    check("result_rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("result_rst_data", {24'd0, res_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 6. 17 operations: the 4-bit counter wraps to 1.
    for (int i = 0; i < 17; i++) begin
      send_byte(W'(i));
      send_byte(8'h01);
      get_result(r);
      if (i == 0 || i == 16) check("wrap_sum", {24'd0, r}, 32'(i + 1));
    end
    check("done_cnt16_17", {16'd0, done_cnt}, 32'd17);
    check("done_cnt4_wrap", {28'd0, done_cnt4}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
